// File: rtl/alu.sv
// 16-bit ALU: combinational add/sub/mul/bitwise plus an 18-cycle restoring divider.
// Define ALU_REG_OUT_EN to register the arithmetic/bitwise outputs (one-cycle latency).
module alu (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        AVALID,
  input  logic        BVALID,
  output logic [31:0] Q,
  output logic        QVALID,
  output logic [15:0] S,
  output logic [15:0] D,
  output logic [15:0] P,
  output logic [15:0] AND_OUT,
  output logic [15:0] OR_OUT,
  output logic [15:0] XOR_OUT
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] dividend, divisor, rem;
  logic [4:0]  iter;
  logic        start, last, sub_ok;
  logic [16:0] shifted;
  logic [15:0] trial;

  logic [15:0] sum_c, diff_c, prod_c, and_c, or_c, xor_c;

  // The exit edge of DONE counts as the first IDLE edge, so held valids restart
  // immediately and results repeat every 18 cycles.
  assign start   = ((state == IDLE) || (state == DONE)) && AVALID && BVALID;
  assign last    = (iter == 5'd16);
  assign shifted = {rem, dividend[15]};
  assign sub_ok  = (shifted >= {1'b0, divisor});
  assign trial   = shifted[15:0] - divisor;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // The dividend register shifts left as quotient bits enter at the bottom.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q        <= 32'd0;
      QVALID   <= 1'b0;
      dividend <= 16'd0;
      divisor  <= 16'd0;
      rem      <= 16'd0;
      iter     <= 5'd0;
    end else begin
      QVALID <= 1'b0;
      if (start) begin
        dividend <= A;
        divisor  <= B;
        rem      <= 16'd0;
        iter     <= 5'd0;
      end else if (state == RUN) begin
        if (last) begin
          Q      <= {dividend, rem};
          QVALID <= 1'b1;
        end else begin
          iter <= iter + 5'd1;
          if (sub_ok) begin
            rem      <= trial;
            dividend <= {dividend[14:0], 1'b1};
          end else begin
            rem      <= shifted[15:0];
            dividend <= {dividend[14:0], 1'b0};
          end
        end
      end
    end
  end

  assign sum_c  = A + B;
  assign diff_c = A - B;
  assign prod_c = A * B;
  assign and_c  = A & B;
  assign or_c   = A | B;
  assign xor_c  = A ^ B;

`ifdef ALU_REG_OUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      S       <= 16'd0;
      D       <= 16'd0;
      P       <= 16'd0;
      AND_OUT <= 16'd0;
      OR_OUT  <= 16'd0;
      XOR_OUT <= 16'd0;
    end else begin
      S       <= sum_c;
      D       <= diff_c;
      P       <= prod_c;
      AND_OUT <= and_c;
      OR_OUT  <= or_c;
      XOR_OUT <= xor_c;
    end
  end
`else
  assign S       = sum_c;
  assign D       = diff_c;
  assign P       = prod_c;
  assign AND_OUT = and_c;
  assign OR_OUT  = or_c;
  assign XOR_OUT = xor_c;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (default build): vector table plus reset, abort and
// back-to-back divider sequences.
module tb_alu;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] A, B;
  logic        AVALID, BVALID;
  logic [31:0] Q;
  logic        QVALID;
  logic [15:0] S, D, P, AND_OUT, OR_OUT, XOR_OUT;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] a, b;
    logic [31:0] q;
    logic [15:0] s, d, p, andv, orv, xorv;
  } vec_t;

  vec_t vecs[8];

  alu dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .AVALID(AVALID), .BVALID(BVALID),
    .Q(Q), .QVALID(QVALID), .S(S), .D(D), .P(P),
    .AND_OUT(AND_OUT), .OR_OUT(OR_OUT), .XOR_OUT(XOR_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Counts edges from the next posedge (capture edge = 1) until QVALID is seen.
  task automatic waitQvalid(input int first, output int n);
    n = 0;
    for (int i = first; i <= 40; i++) begin
      @(posedge CLK); #1;
      if (QVALID === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    int   n;
    v = vecs[idx];
    @(negedge CLK);
    A = v.a; B = v.b; AVALID = 1'b1; BVALID = 1'b1;
    #1;
    checkOutput($sformatf("v%0d S", idx), {16'd0, S}, {16'd0, v.s});
    checkOutput($sformatf("v%0d D", idx), {16'd0, D}, {16'd0, v.d});
    checkOutput($sformatf("v%0d P", idx), {16'd0, P}, {16'd0, v.p});
    checkOutput($sformatf("v%0d AND", idx), {16'd0, AND_OUT}, {16'd0, v.andv});
    checkOutput($sformatf("v%0d OR", idx), {16'd0, OR_OUT}, {16'd0, v.orv});
    checkOutput($sformatf("v%0d XOR", idx), {16'd0, XOR_OUT}, {16'd0, v.xorv});
    @(posedge CLK); #1;
    checkOutput($sformatf("v%0d qvalid at capture", idx), {31'd0, QVALID}, 32'd0);
    @(negedge CLK);
    // Operands and a lone valid change after capture and must not disturb the result.
    A = ~v.a; B = v.a ^ 16'h5a5a; AVALID = 1'b1; BVALID = 1'b0;
    waitQvalid(2, n);
    checkOutput($sformatf("v%0d latency", idx), n, 32'd18);
    checkOutput($sformatf("v%0d Q", idx), Q, v.q);
    @(negedge CLK);
    AVALID = 1'b0;
    @(posedge CLK); #1;
    checkOutput($sformatf("v%0d qvalid width", idx), {31'd0, QVALID}, 32'd0);
    checkOutput($sformatf("v%0d Q hold", idx), Q, v.q);
  endtask

  initial begin
    int n, pulses, prev, highs;

    vecs[0] = '{16'h00DB, 16'h00E6, 32'h000000DB, 16'h01C1, 16'hFFF5, 16'hC4C2, 16'h00C2, 16'h00FF, 16'h003D};
    vecs[1] = '{16'h00DB, 16'h0006, 32'h00240003, 16'h00E1, 16'h00D5, 16'h0522, 16'h0002, 16'h00DF, 16'h00DD};
    vecs[2] = '{16'h0049, 16'h0049, 32'h00010000, 16'h0092, 16'h0000, 16'h14D1, 16'h0049, 16'h0049, 16'h0000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 32'h00010000, 16'hFFFE, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[4] = '{16'h0000, 16'h0000, 32'hFFFF0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{16'h1234, 16'h0000, 32'hFFFF1234, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 16'h1234};
    vecs[6] = '{16'h0005, 16'h0100, 32'h00000005, 16'h0105, 16'hFF05, 16'h0500, 16'h0000, 16'h0105, 16'h0105};
    vecs[7] = '{16'hFFFF, 16'h0001, 32'hFFFF0000, 16'h0000, 16'hFFFE, 16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFE};

    // Reset with valids high: no capture while RST is asserted.
    RST = 1'b1; A = 16'h00DB; B = 16'h00E6; AVALID = 1'b1; BVALID = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset Q", Q, 32'd0);
    checkOutput("reset QVALID", {31'd0, QVALID}, 32'd0);
    checkOutput("S during reset", {16'd0, S}, 32'h000001C1);
    @(negedge CLK);
    RST = 1'b0;
    waitQvalid(1, n);
    checkOutput("first capture after reset latency", n, 32'd18);
    checkOutput("first capture after reset Q", Q, 32'h000000DB);
    @(negedge CLK);
    AVALID = 1'b0; BVALID = 1'b0;
    repeat (2) @(posedge CLK);

    for (int i = 0; i < 8; i++) applyStimulus(i);

    // Abort: reset five edges after capture discards the division.
    @(negedge CLK);
    A = 16'h1234; B = 16'h0007; AVALID = 1'b1; BVALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    AVALID = 1'b0; BVALID = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("abort Q cleared", Q, 32'd0);
    highs = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge CLK); #1;
      if (QVALID === 1'b1) highs++;
    end
    checkOutput("abort no qvalid", highs, 32'd0);
    checkOutput("abort Q stays 0", Q, 32'd0);
    applyStimulus(1);

    // Back-to-back: valids held high for 54 cycles.
    @(negedge CLK);
    A = 16'h00DB; B = 16'h0006; AVALID = 1'b1; BVALID = 1'b1;
    pulses = 0; prev = 0;
    for (int i = 1; i <= 54; i++) begin
      @(posedge CLK); #1;
      if (QVALID === 1'b1) begin
        pulses++;
        checkOutput($sformatf("b2b pulse %0d spacing", pulses), i - prev, 32'd18);
        checkOutput($sformatf("b2b pulse %0d Q", pulses), Q, 32'h00240003);
        prev = i;
      end
    end
    checkOutput("b2b pulse count", pulses, 32'd3);
    @(negedge CLK);
    AVALID = 1'b0; BVALID = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
